// File: rtl/fpu_int_encoder_if.sv
// Operand/result handshake bundle between the integer-to-float encoder and its neighbours.
interface fpu_int_encoder_if;
  logic [31:0] int_in;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_out;
  logic [3:0]  status_out;
  logic        out_valid;
  logic        out_ready;

  modport slave (
    input  int_in, in_valid, out_ready,
    output in_ready, data_out, status_out, out_valid
  );

  modport master (
    output int_in, in_valid, out_ready,
    input  in_ready, data_out, status_out, out_valid
  );
endinterface

// File: rtl/fpu_int_encoder.sv
// Iterative 32-bit signed integer -> packed float {sign, exp[9:0], mant[20:0]} encoder.
// Define INT2FP_RNE_EN for round-to-nearest-even; otherwise the mantissa is truncated.
module fpu_int_encoder #(
  parameter int EXP_BIAS = 511,
  parameter int INT_W    = 32
) (
  input  logic              clock_100Khz,
  input  logic              reset,
  fpu_int_encoder_if.slave  bus
);

  // status_t flag positions: OVERFLOW=0, UNDERFLOW=1, EXACT=2, INEXACT=3
  localparam logic [3:0] ST_EXACT   = 4'b0100;
  localparam logic [3:0] ST_INEXACT = 4'b1000;
  localparam logic [9:0] EXP_INIT   = 10'(EXP_BIAS + INT_W - 1);

  typedef enum logic [1:0] {IDLE, NORMALIZE, ROUND, DONE} state_t;

  state_t      state;
  logic        sign_q;
  logic [31:0] mag_q;
  logic [9:0]  exp_q;
  logic [4:0]  shift_cnt;
  logic [31:0] data_q;
  logic [3:0]  status_q;
  logic        out_valid_q;
  logic        in_ready_q;

  logic [31:0] mag_in;
  logic [20:0] mant_t;
  logic        guard, sticky, round_up;
  logic [21:0] mant_sum;

  assign mag_in   = bus.int_in[31] ? (~bus.int_in + 32'd1) : bus.int_in;
  assign mant_t   = mag_q[30:10];
  assign guard    = mag_q[9];
  assign sticky   = |mag_q[8:0];
`ifdef INT2FP_RNE_EN
  assign round_up = guard & (sticky | mant_t[0]);
`else
  assign round_up = 1'b0;
`endif
  // Bit 21 is the mantissa carry-out; the low 21 bits are then already zero.
  assign mant_sum = {1'b0, mant_t} + {21'd0, round_up};

  always_ff @(posedge clock_100Khz) begin
    if (reset) begin
      state       <= IDLE;
      sign_q      <= 1'b0;
      mag_q       <= '0;
      exp_q       <= '0;
      shift_cnt   <= '0;
      data_q      <= '0;
      status_q    <= ST_EXACT;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (bus.in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            sign_q     <= bus.int_in[31];
            mag_q      <= mag_in;
            exp_q      <= EXP_INIT;
            shift_cnt  <= '0;
            if (bus.int_in == 32'd0) begin
              data_q      <= '0;
              status_q    <= ST_EXACT;
              out_valid_q <= 1'b1;
              state       <= DONE;
            end else begin
              state <= NORMALIZE;
            end
          end
        end
        NORMALIZE: begin
          if (!mag_q[31]) begin
            mag_q <= mag_q << 1;
            exp_q <= exp_q - 10'd1;
            if (shift_cnt != 5'd31) shift_cnt <= shift_cnt + 5'd1;
          end else begin
            state <= ROUND;
          end
        end
        ROUND: begin
          data_q      <= {sign_q, exp_q + {9'd0, mant_sum[21]}, mant_sum[20:0]};
          status_q    <= (guard | sticky) ? ST_INEXACT : ST_EXACT;
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.data_out   = data_q;
  assign bus.status_out = status_q;
  assign bus.out_valid  = out_valid_q;

endmodule

// File: tb/tb_fpu_int_encoder.sv
// Self-checking bench for fpu_int_encoder: directed corner values, random operands vs. an arithmetic model.
module tb_fpu_int_encoder;

  localparam logic [3:0] ST_EXACT   = 4'b0100;
  localparam logic [3:0] ST_INEXACT = 4'b1000;

  logic clock_100Khz = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  fpu_int_encoder_if bus();

  fpu_int_encoder dut (
    .clock_100Khz (clock_100Khz),
    .reset        (reset),
    .bus          (bus)
  );

  always #5 clock_100Khz = ~clock_100Khz;

  // Reference: value = (-1)^s * 1.f * 2^e, rounding decided by comparing the dropped bits to one half.
  task automatic model(input logic [31:0] v, output logic [31:0] d, output logic [3:0] st,
                       output int lat);
    longint m, sc, mant, rem, ex;
    int e;
    bit s;
    if (v == 32'd0) begin
      d = 32'd0; st = ST_EXACT; lat = 1;
      return;
    end
    s = v[31];
    m = s ? (64'h1_0000_0000 - longint'(v)) : longint'(v);
    e = 0;
    for (int k = 0; k < 32; k++) if (m >= (64'd1 << k)) e = k;
    sc   = m << (31 - e);
    mant = (sc / 1024) - (64'd1 << 21);
    rem  = sc % 1024;
    st   = (rem != 0) ? ST_INEXACT : ST_EXACT;
`ifdef INT2FP_RNE_EN
    if (rem > 512 || (rem == 512 && (mant % 2) == 1)) mant = mant + 1;
`endif
    ex = 511 + e;
    if (mant == (64'd1 << 21)) begin mant = 0; ex = ex + 1; end
    d   = {s, ex[9:0], mant[20:0]};
    lat = 34 - e;
  endtask

  // Accept one operand and wait for the result; lat counts the accepting edge as edge 1.
  task automatic run_conv(input logic [31:0] v, output logic [31:0] d, output logic [3:0] st,
                          output int lat, output bit ok);
    int w = 0;
    ok = 1'b0; d = '0; st = '0; lat = 0;
    while (!bus.in_ready && w < 50) begin @(posedge clock_100Khz); #1; w++; end
    if (!bus.in_ready) return;
    bus.int_in   = v;
    bus.in_valid = 1'b1;
    @(posedge clock_100Khz); #1;
    bus.in_valid = 1'b0;
    bus.int_in   = $urandom;
    lat = 1;
    while (!bus.out_valid && lat < 60) begin @(posedge clock_100Khz); #1; lat++; end
    ok = bus.out_valid;
    d  = bus.data_out;
    st = bus.status_out;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.int_in = '0;
    repeat (3) @(posedge clock_100Khz);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.data_out !== 32'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", bus.data_out); end
    checks++; if (bus.status_out !== ST_EXACT) begin errors++; $display("FAIL reset_status got=%h exp=%h", bus.status_out, ST_EXACT); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
    reset = 1'b0;
    @(posedge clock_100Khz); #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_directed;
    logic [31:0] vin [6];
    logic [31:0] xd  [6];
    logic [3:0]  xs  [6];
    int          xl  [6];
    logic [31:0] d; logic [3:0] st; int lat; bit ok;
    vin = '{32'd1, 32'hFFFFFFFF, 32'd3, 32'd0, 32'h80000000, 32'h7FFFFFFF};
`ifdef INT2FP_RNE_EN
    xd  = '{32'h3FE00000, 32'hBFE00000, 32'h40100000, 32'h0, 32'hC3C00000, 32'h43C00000};
`else
    xd  = '{32'h3FE00000, 32'hBFE00000, 32'h40100000, 32'h0, 32'hC3C00000, 32'h43BFFFFF};
`endif
    xs  = '{ST_EXACT, ST_EXACT, ST_EXACT, ST_EXACT, ST_EXACT, ST_INEXACT};
    xl  = '{34, 34, 33, 1, 3, 4};
    for (int i = 0; i < 6; i++) begin
      run_conv(vin[i], d, st, lat, ok);
      checks++; if (!ok) begin errors++; $display("FAIL dir_timeout in=%h no out_valid", vin[i]); end
      checks++; if (d !== xd[i]) begin errors++; $display("FAIL dir_data in=%h got=%h exp=%h", vin[i], d, xd[i]); end
      checks++; if (st !== xs[i]) begin errors++; $display("FAIL dir_status in=%h got=%h exp=%h", vin[i], st, xs[i]); end
      checks++; if (lat !== xl[i]) begin errors++; $display("FAIL dir_latency in=%h got=%0d exp=%0d", vin[i], lat, xl[i]); end
      @(posedge clock_100Khz); #1;
      checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        errors++; $display("FAIL dir_handshake in=%h out_valid=%b in_ready=%b exp 0/1", vin[i], bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] v, d, ed; logic [3:0] st, es; int lat, el; bit ok;
    for (int i = 0; i < 40; i++) begin
      v = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) v = -v;
      model(v, ed, es, el);
      run_conv(v, d, st, lat, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rnd_timeout in=%h", v); end
      checks++; if (d !== ed) begin errors++; $display("FAIL rnd_data in=%h got=%h exp=%h", v, d, ed); end
      checks++; if (st !== es) begin errors++; $display("FAIL rnd_status in=%h got=%h exp=%h", v, st, es); end
      checks++; if (lat !== el) begin errors++; $display("FAIL rnd_latency in=%h got=%0d exp=%0d", v, lat, el); end
      @(posedge clock_100Khz); #1;
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] v, d, ed; logic [3:0] st, es; int lat, el; bit ok;
    v = 32'h00ABCDEF;
    model(v, ed, es, el);
    bus.out_ready = 1'b0;
    run_conv(v, d, st, lat, ok);
    checks++; if (!ok || d !== ed || st !== es) begin
      errors++; $display("FAIL bp_result ok=%b got=%h/%h exp=%h/%h", ok, d, st, ed, es);
    end
    bus.in_valid = 1'b1; bus.int_in = 32'd5;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock_100Khz); #1;
      checks++; if (bus.out_valid !== 1'b1 || bus.data_out !== ed || bus.status_out !== es || bus.in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold cyc=%0d ov=%b data=%h st=%h rdy=%b exp 1/%h/%h/0", i,
                           bus.out_valid, bus.data_out, bus.status_out, bus.in_ready, ed, es);
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clock_100Khz); #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release ov=%b rdy=%b exp 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] v, d, ed; logic [3:0] st, es; int lat, el; bit ok;
    for (int i = 0; i < 4; i++) begin
      v = (i == 0) ? 32'd6 : $urandom;
      model(v, ed, es, el);
      run_conv(v, d, st, lat, ok);
      checks++; if (!ok || d !== ed || st !== es || lat !== el) begin
        errors++; $display("FAIL b2b in=%h got=%h/%h/%0d exp=%h/%h/%0d", v, d, st, lat, ed, es, el);
      end
      @(posedge clock_100Khz); #1;
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d, ed; logic [3:0] st, es; int lat, el; bit ok, seen;
    bus.int_in = 32'd1; bus.in_valid = 1'b1;
    @(posedge clock_100Khz); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clock_100Khz);
    #1; reset = 1'b1;
    @(posedge clock_100Khz); #1;
    reset = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.data_out !== 32'd0 || bus.status_out !== ST_EXACT || bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL mid_reset ov=%b data=%h st=%h rdy=%b exp 0/0/%h/0", bus.out_valid, bus.data_out, bus.status_out, bus.in_ready, ST_EXACT);
    end
    seen = 1'b0;
    repeat (40) begin @(posedge clock_100Khz); #1; if (bus.out_valid) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_reset_ghost got out_valid=1 exp none"); end
    model(32'hFFFFFFFD, ed, es, el);
    run_conv(32'hFFFFFFFD, d, st, lat, ok);
    checks++; if (!ok || d !== ed || st !== es || lat !== el) begin
      errors++; $display("FAIL mid_reset_recover got=%h/%h/%0d exp=%h/%h/%0d", d, st, lat, ed, es, el);
    end
    @(posedge clock_100Khz); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
